// File: rtl/clause_sequencer.sv
// Clause sweep controller: fetches each clause from clause memory, loads it into the
// ClauseRegister and hands it to the evaluator. Optional build macro: CLAUSE_SKIP_ZERO_EN.

`ifndef BIT_WIDTH_OF_INTEGER_VARIABLE
`define BIT_WIDTH_OF_INTEGER_VARIABLE 8
`endif
`ifndef NUMBER_OF_INTEGER_VARIABLES
`define NUMBER_OF_INTEGER_VARIABLES 4
`endif

module clause_sequencer #(
    parameter int NUM_CLAUSES = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int COEFF_WIDTH = `BIT_WIDTH_OF_INTEGER_VARIABLE * `NUMBER_OF_INTEGER_VARIABLES
) (
    input  logic                   in_clk,
    input  logic                   in_reset_n,
    input  logic                   in_start,
    input  logic [ADDR_WIDTH:0]    in_num_clauses,
    output logic [ADDR_WIDTH-1:0]  out_mem_addr,
    output logic                   out_mem_read_enable,
    input  logic [COEFF_WIDTH-1:0] in_mem_data,
    output logic [COEFF_WIDTH-1:0] out_clause_coefficients,
    output logic                   out_clause_write_enable,
    output logic [ADDR_WIDTH-1:0]  out_clause_index,
    output logic                   out_clause_valid,
    input  logic                   in_eval_ready,
    output logic                   out_busy,
    output logic                   out_done,
    output logic [ADDR_WIDTH:0]    out_skipped_count
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   MAX_COUNT = CNT_W'(NUM_CLAUSES);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_PRESENT,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  index_q, index_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [COEFF_WIDTH-1:0] coeff_q, coeff_d;
    logic [ADDR_WIDTH:0]    start_count;
    logic                   last_clause;
    logic                   skip_clause;

    assign start_count = (in_num_clauses > MAX_COUNT) ? MAX_COUNT : in_num_clauses;
    // count_q is never zero outside IDLE/DONE, so count_q-1 cannot underflow here.
    assign last_clause = ({1'b0, index_q} == (count_q - CNT_ONE));

`ifdef CLAUSE_SKIP_ZERO_EN
    logic [ADDR_WIDTH:0] skipped_q, skipped_d;
    assign skip_clause       = (coeff_q == '0);
    assign out_skipped_count = skipped_q;
`else
    assign skip_clause       = 1'b0;
    assign out_skipped_count = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the same pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            count_q <= '0;
            coeff_q <= '0;
`ifdef CLAUSE_SKIP_ZERO_EN
            skipped_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            coeff_q <= coeff_d;
`ifdef CLAUSE_SKIP_ZERO_EN
            skipped_q <= skipped_d;
`endif
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the case
    // statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        coeff_d = coeff_q;
`ifdef CLAUSE_SKIP_ZERO_EN
        skipped_d = skipped_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    count_d = start_count;
                    index_d = '0;
`ifdef CLAUSE_SKIP_ZERO_EN
                    skipped_d = '0;
`endif
                    state_d = (start_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                coeff_d = in_mem_data;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (skip_clause) begin
`ifdef CLAUSE_SKIP_ZERO_EN
                    skipped_d = skipped_q + CNT_ONE;
`endif
                    if (last_clause) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + IDX_ONE;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (in_eval_ready) begin
                    if (last_clause) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + IDX_ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state, so reset forces them all low at once.
    assign out_mem_addr            = index_q;
    assign out_mem_read_enable     = (state_q == S_FETCH);
    assign out_clause_coefficients = coeff_q;
    assign out_clause_write_enable = (state_q == S_LOAD) && !skip_clause;
    assign out_clause_index        = index_q;
    assign out_clause_valid        = (state_q == S_PRESENT);
    assign out_busy                = (state_q != S_IDLE);
    assign out_done                = (state_q == S_DONE);

endmodule

// File: tb/tb_clause_sequencer.sv
// Randomised self-checking bench for clause_sequencer against a sweep-level reference
// model; honours CLAUSE_SKIP_ZERO_EN the same way as the design.
`timescale 1ns/1ps

`ifndef BIT_WIDTH_OF_INTEGER_VARIABLE
`define BIT_WIDTH_OF_INTEGER_VARIABLE 8
`endif
`ifndef NUMBER_OF_INTEGER_VARIABLES
`define NUMBER_OF_INTEGER_VARIABLES 4
`endif

module tb_clause_sequencer;

    localparam int NUM_CLAUSES = 8;
    localparam int ADDR_WIDTH  = 3;
    localparam int CW = `BIT_WIDTH_OF_INTEGER_VARIABLE * `NUMBER_OF_INTEGER_VARIABLES;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef CLAUSE_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH:0]   num_clauses = '0;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [CW-1:0]         mem_data;
    logic [CW-1:0]         coef;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] cl_index;
    logic                  valid;
    logic                  ready = 1'b0;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   skipped;

    logic [CW-1:0] mem [DEPTH];

    int n_vec = 0;
    int n_bad = 0;

    clause_sequencer #(
        .NUM_CLAUSES(NUM_CLAUSES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .COEFF_WIDTH(CW)
    ) dut (
        .in_clk                 (clk),
        .in_reset_n             (rst_n),
        .in_start               (start),
        .in_num_clauses         (num_clauses),
        .out_mem_addr           (mem_addr),
        .out_mem_read_enable    (mem_rd),
        .in_mem_data            (mem_data),
        .out_clause_coefficients(coef),
        .out_clause_write_enable(wr_en),
        .out_clause_index       (cl_index),
        .out_clause_valid       (valid),
        .in_eval_ready          (ready),
        .out_busy               (busy),
        .out_done               (done),
        .out_skipped_count      (skipped)
    );

    always #5 clk = ~clk;

    // Clause memory: one-cycle read latency, garbage on the bus when not strobed.
    always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : CW'($urandom);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},    64'(mem_addr), 0);
        check({tag, "_rd"},      64'(mem_rd),   0);
        check({tag, "_coef"},    64'(coef),     0);
        check({tag, "_wr"},      64'(wr_en),    0);
        check({tag, "_index"},   64'(cl_index), 0);
        check({tag, "_valid"},   64'(valid),    0);
        check({tag, "_busy"},    64'(busy),     0);
        check({tag, "_done"},    64'(done),     0);
        check({tag, "_skipped"}, 64'(skipped),  0);
    endtask

    // Runs one sweep from a negedge in IDLE and compares against the reference model.
    task automatic run_sweep(input string tag, input int n_req, input int max_stall,
                             input int force_pos, input int force_len, input bit noisy,
                             output int done_cycle);
        int            n_eff;
        logic [CW-1:0] exp_wr[$];
        int            exp_idx[$];
        int            stalls[$];
        int            exp_skip;
        int            exp_cycles;
        logic [CW-1:0] got_wr[$];
        logic [CW-1:0] got_coef[$];
        int            got_idx[$];
        int            got_addr[$];
        int            first_rd, busy_n, done_n, cyc, stall_left, hold_bad;
        bit            in_pres;
        logic [CW-1:0] pres_coef;
        int            pres_idx;

        n_eff    = (n_req > NUM_CLAUSES) ? NUM_CLAUSES : n_req;
        exp_skip = 0;
        for (int i = 0; i < n_eff; i++) begin
            if (SKIP && mem[i] == '0) exp_skip++;
            else begin
                exp_wr.push_back(mem[i]);
                exp_idx.push_back(i);
            end
        end
        exp_cycles = 3 * n_eff + exp_idx.size() + 1;
        for (int k = 0; k < exp_idx.size(); k++) begin
            stalls.push_back((k == force_pos) ? force_len : int'($urandom_range(max_stall, 0)));
            exp_cycles += stalls[k];
        end

        first_rd = -1; busy_n = 0; done_n = 0; cyc = 0; stall_left = 0; hold_bad = 0;
        in_pres = 1'b0; pres_coef = '0; pres_idx = 0; done_cycle = -1;

        start = 1'b1;
        num_clauses = (ADDR_WIDTH + 1)'(n_req);
        @(negedge clk);
        start = 1'b0;
        while (cyc < exp_cycles + 20) begin
            cyc++;
            if (busy) busy_n++;
            if (mem_rd) begin
                got_addr.push_back(int'(mem_addr));
                if (first_rd < 0) first_rd = cyc;
            end
            if (wr_en) got_wr.push_back(coef);
            if (valid) begin
                if (!in_pres) begin
                    in_pres    = 1'b1;
                    stall_left = (stalls.size() > 0) ? stalls.pop_front() : 0;
                    pres_coef  = coef;
                    pres_idx   = int'(cl_index);
                end else if (coef !== pres_coef || int'(cl_index) != pres_idx) begin
                    hold_bad++;
                end
                ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                if (ready) begin
                    got_idx.push_back(int'(cl_index));
                    got_coef.push_back(coef);
                end
            end else begin
                in_pres = 1'b0;
                ready   = 1'($urandom_range(1, 0));
            end
            if (done) begin
                done_n++;
                done_cycle = cyc;
            end
            if (noisy) begin
                start       = ($urandom_range(3, 0) == 0);
                num_clauses = (ADDR_WIDTH + 1)'($urandom);
            end
            if (done) break;
            @(negedge clk);
        end
        start = 1'b0;

        check({tag, "_done_pulses"}, 64'(done_n), 1);
        check({tag, "_done_cycle"},  64'(done_cycle), 64'(exp_cycles));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_cycles));
        check({tag, "_first_read"},  64'(first_rd), (n_eff > 0) ? 64'd1 : 64'(-1));
        check({tag, "_num_reads"},   64'(got_addr.size()), 64'(n_eff));
        for (int i = 0; i < got_addr.size() && i < n_eff; i++)
            check($sformatf("%s_read_addr%0d", tag, i), 64'(got_addr[i]), 64'(i));
        check({tag, "_num_writes"},  64'(got_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            check($sformatf("%s_write%0d", tag, i), 64'(got_wr[i]), 64'(exp_wr[i]));
        check({tag, "_num_accepts"}, 64'(got_idx.size()), 64'(exp_idx.size()));
        for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
            check($sformatf("%s_accept_idx%0d", tag, i), 64'(got_idx[i]), 64'(exp_idx[i]));
            check($sformatf("%s_accept_coef%0d", tag, i), 64'(got_coef[i]), 64'(exp_wr[i]));
        end
        check({tag, "_hold_steady"}, 64'(hold_bad), 0);
        check({tag, "_skipped"},     64'(skipped), 64'(exp_skip));
        @(negedge clk);
        check({tag, "_idle_busy"},    64'(busy), 0);
        check({tag, "_idle_done"},    64'(done), 0);
        check({tag, "_skipped_hold"}, 64'(skipped), 64'(exp_skip));
    endtask

    initial begin : main
        int dcyc;
        int waited;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset state and quiet idle after release.
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_release", 64'(busy), 0);

        // Full sweep of 7,8,9: done on cycle 13.
        mem[0] = CW'(7); mem[1] = CW'(8); mem[2] = CW'(9);
        run_sweep("full", 3, 0, -1, 0, 1'b0, dcyc);
        check("full_done_on_13", 64'(dcyc), 13);

        // Backpressure: clause 1 held for 5 cycles.
        for (int i = 0; i < DEPTH; i++) mem[i] = CW'($urandom_range(1000, 1));
        run_sweep("backpressure", 3, 0, 1, 5, 1'b0, dcyc);

        // Zero-length sweep: DONE only.
        run_sweep("zero_len", 0, 0, -1, 0, 1'b0, dcyc);
        check("zero_len_done_cycle", 64'(dcyc), 1);

        // Oversized request clamps to NUM_CLAUSES.
        run_sweep("clamp12", 12, 1, -1, 0, 1'b0, dcyc);

        // Start pulses and count changes mid-sweep are ignored.
        run_sweep("start_busy", 4, 1, -1, 0, 1'b1, dcyc);

        // All-zero clause in the middle.
        mem[0] = CW'(5); mem[1] = '0; mem[2] = CW'(6);
        run_sweep("zero_clause", 3, 0, -1, 0, 1'b0, dcyc);
        check("zero_clause_skipped", 64'(skipped), SKIP ? 64'd1 : 64'd0);

        // Randomised sweeps.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] = ($urandom_range(2, 0) == 0) ? '0 : CW'($urandom | 1);
            run_sweep($sformatf("rand%0d", t), int'($urandom_range(15, 0)), 3, -1, 0,
                      1'($urandom_range(1, 0)), dcyc);
        end

        // Reset asserted while a clause is presented.
        for (int i = 0; i < DEPTH; i++) mem[i] = CW'($urandom_range(1000, 1));
        ready = 1'b0;
        start = 1'b1;
        num_clauses = 3;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("midreset_reached_present", 64'(valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_idle_busy", 64'(busy), 0);
        check("midreset_idle_valid", 64'(valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/clause_sequencer.md
# clause_sequencer

Controller that sweeps the clause list of the MCMC constraint solver. On a start pulse it reads each clause's coefficient vector from the clause memory and loads it into the ClauseRegister through that register's write-enable port. It then presents the loaded clause to the clause evaluator with a valid/ready handshake and advances to the next clause. It sits between the clause memory and the ClauseRegister/evaluator pair and owns the register's write port exclusively.

## Interface

Parameters:
- NUM_CLAUSES, 8, maximum clauses per sweep
- ADDR_WIDTH, 3, clause memory address width; NUM_CLAUSES ≤ 2**ADDR_WIDTH
- COEFF_WIDTH, `BIT_WIDTH_OF_INTEGER_VARIABLE * `NUMBER_OF_INTEGER_VARIABLES, width of one clause coefficient vector

Ports:
- in_clk  input  1  single clock, rising edge
- in_reset_n  input  1  asynchronous, active-low reset
- in_start  input  1  start a sweep; sampled only in IDLE
- in_num_clauses  input  ADDR_WIDTH+1  clauses in this sweep; sampled with in_start
- out_mem_addr  output  ADDR_WIDTH  clause memory read address
- out_mem_read_enable  output  1  clause memory read strobe
- in_mem_data  input  COEFF_WIDTH  read data, valid exactly one cycle after the strobe
- out_clause_coefficients  output  COEFF_WIDTH  data to ClauseRegister in_clause_coefficients
- out_clause_write_enable  output  1  to ClauseRegister in_write_enable
- out_clause_index  output  ADDR_WIDTH  index of the clause currently presented
- out_clause_valid  output  1  ClauseRegister contents are valid for the evaluator
- in_eval_ready  input  1  evaluator accepts the current clause
- out_busy  output  1  sweep in progress
- out_done  output  1  one-cycle pulse at end of sweep
- out_skipped_count  output  ADDR_WIDTH+1  number of all-zero clauses skipped in the last sweep

## Operation

- States: IDLE, FETCH, WAIT, LOAD, PRESENT, DONE.
- IDLE: when in_start=1, latch the sweep count as min(in_num_clauses, NUM_CLAUSES) and clear the index and skip counter.
  - Count of 0 → DONE.
  - Otherwise → FETCH.
- FETCH: out_mem_read_enable=1, out_mem_addr=index → WAIT.
- WAIT: in_mem_data is captured into out_clause_coefficients at the end of this cycle → LOAD.
- LOAD: out_clause_write_enable=1 for exactly one cycle → PRESENT.
- PRESENT: out_clause_valid=1 and out_clause_index=index.
  - On in_eval_ready=1 in this state, the clause is accepted.
  - If index = count−1 → DONE; else index+1 → FETCH.
  - With ready low, stay in PRESENT and hold all outputs.
- DONE: out_done=1 for one cycle → IDLE.
- out_busy=1 in every state except IDLE.
- in_start outside IDLE is ignored.
- in_num_clauses changes after the sample have no effect.
- The index never wraps; a sweep ends at count−1.
- out_clause_coefficients holds its last value between sweeps.
- out_skipped_count holds its value until the next start.

## Timing

- Reset (in_reset_n=0), effective immediately and asynchronously in any state: state IDLE, and every output 0 (addr, read strobe, coefficients, write enable, index, valid, busy, done, skipped count).
- Reset release: first state change on the first rising edge with in_reset_n=1 and in_start=1.
- Start to first out_mem_read_enable: 1 cycle.
- Per clause with in_eval_ready held high: 4 cycles (FETCH, WAIT, LOAD, PRESENT).
- The evaluator sees valid ClauseRegister output in PRESENT, since the register updates on the LOAD edge.
- A sweep of N clauses with ready held high is 4N+1 cycles of busy, including DONE. A count of 0 gives 1 cycle of busy (DONE only).

## Configuration

- CLAUSE_SKIP_ZERO_EN defined:
  - In LOAD, if the captured coefficient vector is all zero, do not assert write enable or valid.
  - Increment out_skipped_count, then take the index-advance/DONE decision in the same state without entering PRESENT.
  - A skipped clause costs 3 cycles.
- CLAUSE_SKIP_ZERO_EN undefined:
  - Every clause is loaded and presented regardless of value.
  - out_skipped_count is tied to 0.

## Test plan

- Reset mid-sweep: assert in_reset_n=0 while in PRESENT → all outputs 0 immediately; after release, idle with out_busy=0.
- Full sweep: memory holds 7,8,9 at addresses 0..2, in_num_clauses=3, ready high → write enable pulses carry 7,8,9; out_done pulses on cycle 13 after start.
- Backpressure: ready low for 5 cycles in PRESENT of clause 1 → valid, index=1 and coefficients held steady; no extra write enable; sweep completes on ready.
- Boundaries: in_num_clauses=0 → single out_done pulse, no memory read. in_num_clauses=12 with NUM_CLAUSES=8 → exactly 8 clauses, last index 7.
- Start while busy: in_start pulsed during clause 2 → ignored, sweep count unchanged.
- With CLAUSE_SKIP_ZERO_EN, memory holding 5,0,6 → write enables carry 5 and 6 only, out_skipped_count=1. Without the macro → three presentations, count 0.
